// File: rtl/complex_dot_product_scheduler.sv
// ---------------------------------------------------------------------------
// complex_dot_product_scheduler
//
// Round-robin scheduler sharing one conjugate-complex eight-lane dot-product
// engine among NREQ requesters. Each job is granted to one requester and
// sequenced as:
//   LOAD (start pulse) -> STREAM (package strobes every PKT_GAP cycles)
//   -> DRAIN (wait for engine finish) -> DONE (result + clear)
// A zero-length job goes straight to DONE. A length that is not a multiple
// of NO_OF_UNITS goes straight to FAIL.
//
// Optional feature macro: DOTP_SCHED_TIMEOUT_EN
//   defined   : DRAIN watchdog. TIMEOUT DRAIN cycles without eng_finish -> FAIL
//   undefined : DRAIN waits on eng_finish indefinitely (no counter)
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   req          : per-requester level request, held until done/err
//   req_len      : per-requester element count, slot i at [i*LEN_WIDTH +: LEN_WIDTH]
//   grant        : one-hot engine owner, stable for the whole job
//   pkt_rd       : strobe, owner presents package pkt_idx on the next cycle
//   pkt_idx      : package index within the job
//   done / err   : one-cycle completion / error pulse to the owner
//   result       : dot product, valid while done is high
//   eng_start    : engine read-now pulse
//   eng_total    : zero-extended element count for the engine
//   eng_clear    : engine reset
//   eng_finish   : engine finish (sticky until eng_clear)
//   eng_result   : engine dot product
// ---------------------------------------------------------------------------
module complex_dot_product_scheduler #(
    parameter int NREQ          = 4,
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 64,
    parameter int LEN_WIDTH     = 16,
    parameter int PKT_GAP       = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LEN_WIDTH-1:0] req_len,
    output logic [NREQ-1:0]           grant,
    output logic                      pkt_rd,
    output logic [LEN_WIDTH-1:0]      pkt_idx,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic [ELEMENT_WIDTH-1:0]  result,
    output logic                      eng_start,
    output logic [31:0]               eng_total,
    output logic                      eng_clear,
    input  logic                      eng_finish,
    input  logic [ELEMENT_WIDTH-1:0]  eng_result
);

    localparam int          PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          GAP_W  = (PKT_GAP > 1) ? $clog2(PKT_GAP + 1) : 1;
    localparam int unsigned NREQ_U = NREQ;
    localparam int unsigned UNITS  = NO_OF_UNITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE,
        FAIL
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [LEN_WIDTH-1:0] num_pkts;
    logic [GAP_W-1:0]     gap_cnt;

`ifdef DOTP_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] drain_cnt;
`endif

    // -----------------------------------------------------------------------
    // Round-robin pick: first requester at or after ptr, wrapping.
    // -----------------------------------------------------------------------
    logic                 any_req;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     cand_idx;
    logic [NREQ-1:0]      win_onehot;
    logic [LEN_WIDTH-1:0] win_len;
    logic [LEN_WIDTH-1:0] win_pkts;
    logic                 win_misaligned;
    logic [PTR_W-1:0]     ptr_next;
    int unsigned          cand;

    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        win_len  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            cand     = (32'(ptr) + i) % NREQ_U;
            cand_idx = PTR_W'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req = 1'b1;
                win_idx = cand_idx;
                win_len = LEN_WIDTH'(req_len >> (cand * 32'(LEN_WIDTH)));
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_pkts            = LEN_WIDTH'(32'(win_len) / UNITS);
        win_misaligned      = (32'(win_len) % UNITS) != 0;
        ptr_next            = (32'(win_idx) == NREQ_U - 1) ? '0 : win_idx + 1'b1;
    end

    // -----------------------------------------------------------------------
    // Job sequencer. Every output is registered and set on the transition
    // into the state it belongs to, so pulses line up with the state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            pkt_rd    <= 1'b0;
            pkt_idx   <= '0;
            result    <= '0;
            eng_start <= 1'b0;
            eng_total <= '0;
            eng_clear <= 1'b1;
            num_pkts  <= '0;
            gap_cnt   <= '0;
`ifdef DOTP_SCHED_TIMEOUT_EN
            drain_cnt <= '0;
`endif
        end else begin
            // single-cycle pulses default low
            done      <= '0;
            err       <= '0;
            eng_start <= 1'b0;
            eng_clear <= 1'b0;
            pkt_rd    <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= win_onehot;
                        ptr       <= ptr_next;
                        eng_total <= 32'(win_len);
                        num_pkts  <= win_pkts;
                        pkt_idx   <= '0;
                        if (win_len == '0) begin
                            state     <= DONE;
                            done      <= win_onehot;
                            result    <= '0;
                            eng_clear <= 1'b1;
                        end else if (win_misaligned) begin
                            state     <= FAIL;
                            err       <= win_onehot;
                            eng_clear <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            eng_start <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    state   <= STREAM;
                    pkt_rd  <= 1'b1;
                    pkt_idx <= '0;
                    gap_cnt <= '0;
                end

                STREAM: begin
                    // gap_cnt counts cycles since the last strobe
                    if (pkt_rd && (pkt_idx == num_pkts - 1'b1)) begin
                        state <= DRAIN;
`ifdef DOTP_SCHED_TIMEOUT_EN
                        drain_cnt <= '0;
`endif
                    end else if (gap_cnt == GAP_W'(PKT_GAP - 1)) begin
                        pkt_rd  <= 1'b1;
                        pkt_idx <= pkt_idx + 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (eng_finish) begin
                        state     <= DONE;
                        done      <= grant;
                        result    <= eng_result;
                        eng_clear <= 1'b1;
                    end
`ifdef DOTP_SCHED_TIMEOUT_EN
                    else if (drain_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= FAIL;
                        err       <= grant;
                        eng_clear <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
`endif
                end

                DONE, FAIL: begin
                    state <= IDLE;
                    grant <= '0;
                end

                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_dot_product_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for complex_dot_product_scheduler (NREQ=4, L multiples
// of 8, PKT_GAP=2, TIMEOUT=16). The timeout scenario is exercised only when
// DOTP_SCHED_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_complex_dot_product_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_len;
    logic [3:0]  grant;
    logic        pkt_rd;
    logic [15:0] pkt_idx;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [63:0] result;
    logic        eng_start;
    logic [31:0] eng_total;
    logic        eng_clear;
    logic        eng_finish;
    logic [63:0] eng_result;

    int checks = 0;
    int errors = 0;

    complex_dot_product_scheduler #(
        .NREQ(4),
        .NO_OF_UNITS(8),
        .ELEMENT_WIDTH(64),
        .LEN_WIDTH(16),
        .PKT_GAP(2),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_len(req_len),
        .grant(grant),
        .pkt_rd(pkt_rd),
        .pkt_idx(pkt_idx),
        .done(done),
        .err(err),
        .result(result),
        .eng_start(eng_start),
        .eng_total(eng_total),
        .eng_clear(eng_clear),
        .eng_finish(eng_finish),
        .eng_result(eng_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_len    = '0;
        eng_finish = 1'b0;
        eng_result = '0;

        // ---------------- reset values ----------------
        tick;
        tick;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pkt_rd", pkt_rd, 0);
        check("rst_pkt_idx", pkt_idx, 0);
        check("rst_result", result, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_total", eng_total, 0);
        check("rst_eng_clear", eng_clear, 1);

        // ---------------- single job: req[1], L=32, P=4 ----------------
        reset          = 1'b0;
        req            = 4'b0010;
        req_len[16+:16] = 16'd32;
        check("release_eng_clear", eng_clear, 1);     // cycle 0
        tick;                                         // cycle 1: LOAD
        check("j1_grant", grant, 4'b0010);
        check("j1_eng_start", eng_start, 1);
        check("j1_eng_total", eng_total, 32);
        check("j1_eng_clear_low", eng_clear, 0);
        // finish outside DRAIN must be ignored
        eng_finish = 1'b1;
        eng_result = 64'hdead;
        tick;                                         // cycle 2: pkt 0
        check("j1_pkt_rd0", pkt_rd, 1);
        check("j1_pkt_idx0", pkt_idx, 0);
        check("j1_eng_start_low", eng_start, 0);
        eng_finish = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick;                                     // gap cycle
            check("j1_gap_pkt_rd", pkt_rd, 0);
            check("j1_gap_done", done, 0);
            check("j1_gap_grant", grant, 4'b0010);
            tick;                                     // cycle 2+2k
            check("j1_pkt_rd", pkt_rd, 1);
            check("j1_pkt_idx", pkt_idx, 64'(k));
        end
        for (int c = 9; c <= 12; c++) begin
            tick;                                     // DRAIN, no finish yet
            check("j1_drain_pkt_rd", pkt_rd, 0);
            check("j1_drain_done", done, 0);
        end
        tick;                                         // cycle 13
        check("j1_c13_done", done, 0);
        eng_finish = 1'b1;
        eng_result = 64'h0000000500000003;
        tick;                                         // cycle 14: DONE
        check("j1_done", done, 4'b0010);
        check("j1_result", result, 64'h0000000500000003);
        check("j1_done_clear", eng_clear, 1);
        check("j1_done_grant", grant, 4'b0010);
        req        = '0;
        eng_finish = 1'b0;
        tick;                                         // cycle 15: IDLE
        check("j1_idle_done", done, 0);
        check("j1_idle_grant", grant, 0);
        check("j1_idle_clear", eng_clear, 0);
        check("j1_result_hold", result, 64'h0000000500000003);

        // ---------------- misaligned: req[0], L=12 ----------------
        req            = 4'b0001;
        req_len[0+:16] = 16'd12;
        tick;
        check("mis_err", err, 4'b0001);
        check("mis_grant", grant, 4'b0001);
        check("mis_clear", eng_clear, 1);
        check("mis_eng_start", eng_start, 0);
        check("mis_done", done, 0);
        check("mis_result_keep", result, 64'h0000000500000003);
        req = '0;
        tick;
        check("mis_idle_err", err, 0);
        check("mis_idle_grant", grant, 0);
        check("mis_idle_pkt_rd", pkt_rd, 0);

        // ---------------- zero length: req[2], L=0 ----------------
        req             = 4'b0100;
        req_len[32+:16] = 16'd0;
        tick;
        check("zero_done", done, 4'b0100);
        check("zero_grant", grant, 4'b0100);
        check("zero_result", result, 0);
        check("zero_eng_start", eng_start, 0);
        check("zero_pkt_rd", pkt_rd, 0);
        req = '0;
        tick;
        check("zero_idle_done", done, 0);
        check("zero_idle_pkt_rd", pkt_rd, 0);
        check("zero_idle_eng_start", eng_start, 0);

`ifdef DOTP_SCHED_TIMEOUT_EN
        // ---------------- DRAIN timeout: req[3], L=8, no finish ----------------
        req             = 4'b1000;
        req_len[48+:16] = 16'd8;
        tick;                                         // cycle 1: LOAD
        check("to_grant", grant, 4'b1000);
        check("to_eng_start", eng_start, 1);
        tick;                                         // cycle 2: pkt 0
        check("to_pkt_rd", pkt_rd, 1);
        tick;                                         // cycle 3: first DRAIN
        for (int i = 0; i < 15; i++) begin
            check("to_wait_err", err, 0);
            tick;
        end
        check("to_c18_err", err, 0);                  // 16th DRAIN cycle
        tick;                                         // cycle 19: FAIL
        check("to_err", err, 4'b1000);
        check("to_clear", eng_clear, 1);
        check("to_done", done, 0);
        req = '0;
        tick;                                         // IDLE
        check("to_idle_err", err, 0);
        req            = 4'b0001;
        req_len[0+:16] = 16'd8;
        tick;
        check("to_next_grant", grant, 4'b0001);
        check("to_next_start", eng_start, 1);
        tick;
        check("to_next_pkt", pkt_rd, 1);
        tick;
        eng_finish = 1'b1;
        eng_result = 64'h77;
        tick;
        check("to_next_done", done, 4'b0001);
        check("to_next_result", result, 64'h77);
        req        = '0;
        eng_finish = 1'b0;
        tick;
`endif

        // ---------------- reset during STREAM ----------------
        req             = 4'b0100;
        req_len[32+:16] = 16'd16;
        tick;                                         // LOAD
        check("rs_grant", grant, 4'b0100);
        tick;                                         // pkt 0
        check("rs_pkt_rd", pkt_rd, 1);
        tick;                                         // gap cycle in STREAM
        reset   = 1'b1;
        req     = 4'b1111;
        req_len = {16'd8, 16'd8, 16'd8, 16'd8};
        tick;
        check("rs_in_grant", grant, 0);
        check("rs_in_pkt_rd", pkt_rd, 0);
        check("rs_in_pkt_idx", pkt_idx, 0);
        check("rs_in_eng_start", eng_start, 0);
        check("rs_in_eng_total", eng_total, 0);
        check("rs_in_result", result, 0);
        check("rs_in_clear", eng_clear, 1);
        check("rs_in_done", done, 0);
        check("rs_in_err", err, 0);
        tick;
        check("rs_in2_done", done, 0);
        reset = 1'b0;
        check("rs_rel_clear", eng_clear, 1);
        check("rs_rel_grant", grant, 0);
        tick;                                         // LOAD, ptr restarted at 0

        // ---------------- fairness: req=1111 held, L=8 each ----------------
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            check("fair_grant", grant, exp_g);
            check("fair_eng_start", eng_start, 1);
            check("fair_eng_total", eng_total, 8);
            tick;
            check("fair_pkt_rd", pkt_rd, 1);
            check("fair_pkt_idx", pkt_idx, 0);
            tick;                                     // DRAIN
            check("fair_drain_pkt_rd", pkt_rd, 0);
            check("fair_drain_done", done, 0);
            eng_finish = 1'b1;
            eng_result = 64'h100 + 64'(k);
            tick;                                     // DONE
            check("fair_done", done, exp_g);
            check("fair_result", result, 64'h100 + 64'(k));
            check("fair_clear", eng_clear, 1);
            eng_finish = 1'b0;
            if (k == 4) req = '0;
            tick;                                     // IDLE
            check("fair_idle_grant", grant, 0);
            check("fair_idle_done", done, 0);
            tick;                                     // next LOAD or idle
        end
        check("fair_end_grant", grant, 0);
        check("fair_end_eng_start", eng_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_dot_product_scheduler.md
# complex_dot_product_scheduler

Round-robin scheduler that shares one conjugate-complex eight-lane dot-product engine among NREQ requesters. It grants the engine to one requester per job and sequences that job: start pulse, package streaming at the engine's half-rate cadence, and drain until the engine's finish. It returns the result to the granted requester and clears the engine for the next job. It sits between the solver stages that own the operand buffers and the dot-product engine.

## Interface
- NREQ, 4, number of requesters (2..8)
- NO_OF_UNITS, 8, complex elements per package
- ELEMENT_WIDTH, 64, complex element width (32 re / 32 im)
- LEN_WIDTH, 16, width of per-requester element count
- PKT_GAP, 2, cycles between package strobes (engine consumes half a package per cycle)
- TIMEOUT, 1024, maximum DRAIN cycles
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NREQ  job request per requester, level, held until its done
- req_len  in  NREQ*LEN_WIDTH  element count per requester, requester i at bits [i*LEN_WIDTH +: LEN_WIDTH]
- grant  out  NREQ  one-hot owner of the engine
- pkt_rd  out  1  strobe: granted requester presents package pkt_idx to the engine on the next cycle
- pkt_idx  out  LEN_WIDTH  package index within the job
- done  out  NREQ  one-cycle completion pulse to the owner
- err  out  NREQ  one-cycle error pulse to the owner
- result  out  ELEMENT_WIDTH  dot product; valid while done is high
- eng_start  out  1  engine read-now pulse
- eng_total  out  32  element count for the engine, zero-extended req_len
- eng_clear  out  1  engine reset
- eng_finish  in  1  engine finish, level, sticky until eng_clear
- eng_result  in  ELEMENT_WIDTH  engine dot product

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE, FAIL.
- IDLE: if any req is high, the scheduler picks the first requester at or after ptr (wrapping) and latches its length L. Next state is LOAD, or DONE if L==0, or FAIL if L mod NO_OF_UNITS != 0. Then ptr = winner+1 mod NREQ.
- LOAD: eng_start=1 for exactly this cycle. Next state is STREAM.
- STREAM: pkt_rd fires on the first STREAM cycle and then every PKT_GAP cycles, with pkt_idx = 0..P-1 where P = L/NO_OF_UNITS. The cycle after the strobe with pkt_idx = P-1, the state goes to DRAIN.
- DRAIN: wait for eng_finish=1, then go to DONE. A cycle counter reaches TIMEOUT only when the timeout feature is compiled in (see Configuration); at TIMEOUT the state goes to FAIL.
- DONE: done[owner]=1 and result=eng_result (0 when L==0). eng_clear=1 for this cycle. Next state is IDLE, and grant drops.
- FAIL: err[owner]=1 and eng_clear=1 for one cycle. result keeps its previous value. Next state is IDLE.
- Deassertion of req during a job is ignored; the job completes. New requests wait in IDLE arbitration. Packages are strictly in order.
- Reset values: state IDLE, ptr 0, grant 0, done 0, err 0, pkt_rd 0, pkt_idx 0, result 0, eng_start 0, eng_total 0, eng_clear 1. eng_clear stays high while reset is high and for the first cycle after reset release.
- Reset mid-job aborts the job with no done or err pulse. The engine is cleared via eng_clear.

## Timing
- Cycle 0: req seen in IDLE. Cycle 1: grant and eng_start high (LOAD). Cycle 2: first pkt_rd. pkt_rd k fires at cycle 2 + k*PKT_GAP.
- grant stays stable from cycle 1 through the DONE or FAIL cycle inclusive.
- The DONE cycle is the cycle after eng_finish is first sampled high in DRAIN.
- Zero-length and misaligned jobs take 2 cycles: cycle 1 is DONE or FAIL, and no eng_start is issued.
- Back-to-back jobs: the next grant is two cycles after DONE (IDLE, then LOAD). The engine has therefore been cleared for at least one cycle before the next eng_start.
- eng_finish high outside DRAIN is ignored.

## Configuration
- DOTP_SCHED_TIMEOUT_EN defined: the DRAIN watchdog is active. A DRAIN lasting TIMEOUT cycles without eng_finish goes to FAIL (err pulse, eng_clear).
- DOTP_SCHED_TIMEOUT_EN undefined: no counter. DRAIN waits on eng_finish indefinitely.

## Test plan
- Single job, req[1]=1, L=32 (P=4): grant=0010 at cycle 1, pkt_rd at cycles 2,4,6,8 with pkt_idx 0..3. The engine model raises finish 5 cycles after the last package with result 0x0000000500000003. Expect done[1] and result=0x0000000500000003 on the cycle after finish, plus an eng_clear pulse.
- Fairness: req=1111 held, L=8 each. Grants are 0001, 0010, 0100, 1000, 0001, each job completing before the next grant.
- L=0 on req[2]: done[2] at cycle 1 with result 0. No eng_start and no pkt_rd.
- L=12 on req[0]: err[0] at cycle 1. No engine activity.
- With DOTP_SCHED_TIMEOUT_EN, TIMEOUT=16, and the engine never finishing: err pulses after 16 DRAIN cycles with eng_clear. The following request is served normally.
- reset asserted during STREAM: on release all outputs are at reset values, eng_clear is high, and no done or err pulse occurs. The first grant afterwards goes to the lowest-index requester (ptr=0).
